dir_input_queue: RTL
====================

DIR_INPUT_QUEUE -- requirements
Module: dir_input_queue

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 16, meaning consecutive stable cycles a synchronised button level must hold before it is accepted (legal range 1..65535).
REQ-002 SHALL have parameter QUEUE_DEPTH, default 4, meaning number of pending direction entries (power of 2, 2..16).
REQ-003 SHALL have parameter ALLOW_REVERSE, default 0, meaning 1 accepts 180-degree turns and 0 rejects them.
REQ-004 SHALL have port clk, input, 1, meaning the single clock; all state is clocked on its rising edge.
REQ-005 SHALL have port reset, input, 1, meaning asynchronous, active-high reset.
REQ-006 SHALL have port button, input, 4, meaning raw asynchronous push-buttons, active high.
REQ-007 SHALL have port tick, input, 1, meaning one-cycle game-step strobe, synchronous to clk.
REQ-008 SHALL have port direction, output, 5, meaning registered one-hot current direction.
REQ-009 SHALL have port queue_count, output, clog2(QUEUE_DEPTH)+1, meaning pending entries.
REQ-010 SHALL have port queue_full, output, 1, meaning queue_count == QUEUE_DEPTH.
REQ-011 SHALL have port drop, output, 1, meaning registered one-cycle pulse when a press event is discarded.

Function
REQ-012 SHALL encode directions one-hot as follows: IDLE=10000, button[0]=01000, button[1]=00001, button[2]=00010, button[3]=00100.
REQ-013 SHALL treat 01000/00100 as an opposite pair and 00001/00010 as an opposite pair; IDLE has no opposite.
REQ-014 SHALL pass each button through a 2-flop synchroniser followed by a per-button debounce counter.
REQ-015 SHALL flip a button's debounced level only after the synchronised level differs from it for DEBOUNCE_CYCLES consecutive cycles; any return to equality clears the counter.
REQ-016 SHALL generate a press event only on a debounced 0->1 transition; releases generate no event, and a held button generates exactly one event.
REQ-017 SHALL perform the enqueue write at edge DEBOUNCE_CYCLES+2, where edge 1 is the first edge that samples the new raw level.
REQ-018 SHALL, when several press events occur in one cycle, keep only the lowest-index button and discard the rest with drop asserted.
REQ-019 SHALL define the reference as the queue tail entry if the queue is non-empty, else direction, both taken as the value before the current edge.
REQ-020 SHALL discard a candidate (drop=1) if it equals the reference, or if ALLOW_REVERSE=0 and it is opposite to the reference.
REQ-021 SHALL discard a candidate (drop=1) when the queue is full, unless tick pops in the same cycle, in which case the push is accepted and queue_count is unchanged.
REQ-022 SHALL, on tick with a non-empty queue, load direction with the head entry and pop, with the new direction visible after that edge.
REQ-023 SHALL hold direction on tick with an empty queue.
REQ-024 SHALL never bypass the queue: a press arriving in the same cycle as tick with an empty queue is enqueued and is applied only on the next tick.
REQ-025 SHALL, on simultaneous push and pop with a non-full queue, leave queue_count unchanged and keep FIFO order.
REQ-026 SHALL wrap queue read and write pointers modulo QUEUE_DEPTH.
REQ-027 SHALL assert drop for exactly one cycle per discarding edge, even if several reasons apply.

Reset
REQ-028 SHALL, on reset assertion and regardless of clk, set direction=10000, queue_count=0, queue_full=0, drop=0, and clear pointers, synchronisers, debounced levels and counters.
REQ-029 SHALL, when reset is asserted mid-operation, discard all pending entries.
REQ-030 SHALL, for a button held high through reset release, produce one press event after the normal debounce latency.

Verification
REQ-031 SHALL verify debounce with DEBOUNCE_CYCLES=4: button[1] high and stable -> queue_count 0->1 at edge 6; a pulse of 3 cycles -> no event.
REQ-032 SHALL verify press/tick after reset: press button[0] then tick -> direction 10000->01000 on the edge after tick; a further tick with an empty queue -> direction holds 01000.
REQ-033 SHALL verify reverse rejection with ALLOW_REVERSE=0 and direction=01000: press button[3] -> drop pulse, count 0; with ALLOW_REVERSE=1 the same press -> count 1.
REQ-034 SHALL verify queue fill with QUEUE_DEPTH=4: enqueue 00001,01000,00010,00100 -> queue_full=1; a 5th valid press -> drop; same press coincident with tick -> accepted, count stays 4, subsequent ticks yield FIFO order.
REQ-035 SHALL verify simultaneous presses: button[2] and button[1] debounce on the same edge -> 00001 enqueued, drop=1 for one cycle.
REQ-036 SHALL verify reset mid-operation: reset asserted with 3 entries pending -> direction=10000 and count=0 immediately, without waiting for a clk edge.

Source files
------------

// File: rtl/dir_input_queue.sv
// Debounced four-button direction input feeding a small FIFO of pending moves;
// each game tick pops the oldest pending move into the registered direction.
module dir_input_queue #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int QUEUE_DEPTH     = 4,
    parameter int ALLOW_REVERSE   = 0
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [3:0]                     button,
    input  logic                           tick,
    output logic [4:0]                     direction,
    output logic [$clog2(QUEUE_DEPTH):0]   queue_count,
    output logic                           queue_full,
    output logic                           drop
);

    localparam int PW = $clog2(QUEUE_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [4:0]    DIR_IDLE = 5'b10000;
    localparam logic [15:0]   CNT_LAST = 16'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(QUEUE_DEPTH);

    function automatic logic [4:0] button_dir(input int idx);
        case (idx)
            0:       button_dir = 5'b01000;
            1:       button_dir = 5'b00001;
            2:       button_dir = 5'b00010;
            default: button_dir = 5'b00100;
        endcase
    endfunction

    function automatic logic [4:0] opposite(input logic [4:0] d);
        case (d)
            5'b01000: opposite = 5'b00100;
            5'b00100: opposite = 5'b01000;
            5'b00001: opposite = 5'b00010;
            5'b00010: opposite = 5'b00001;
            default:  opposite = 5'b00000;
        endcase
    endfunction

    logic [3:0]  sync1, sync2, deb;
    logic [15:0] cnt [4];
    logic [3:0]  press;

    // The press fires on the same edge the debounced level flips, so the
    // enqueue lands DEBOUNCE_CYCLES+2 edges after the raw change.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            press[i] = sync2[i] & ~deb[i] & (cnt[i] == CNT_LAST);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
            deb   <= '0;
            for (int i = 0; i < 4; i++) cnt[i] <= '0;
        end else begin
            sync1 <= button;
            sync2 <= sync1;
            for (int i = 0; i < 4; i++) begin
                if (sync2[i] == deb[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_LAST) begin
                    deb[i] <= sync2[i];
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 16'd1;
                end
            end
        end
    end

    logic [4:0]    mem [QUEUE_DEPTH];
    logic [PW-1:0] rd_ptr, wr_ptr;
    logic [4:0]    cand_dir, ref_dir;
    logic          cand_valid, multi, reject, push, pop, full, drop_next;

    assign full = (queue_count == CNT_FULL);
    assign pop  = tick && (queue_count != '0);

    always_comb begin
        cand_valid = 1'b0;
        cand_dir   = '0;
        multi      = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (press[i]) begin
                if (!cand_valid) begin
                    cand_valid = 1'b1;
                    cand_dir   = button_dir(i);
                end else begin
                    multi = 1'b1;
                end
            end
        end
        ref_dir   = (queue_count != '0) ? mem[wr_ptr - PW'(1)] : direction;
        reject    = cand_valid &&
                    ((cand_dir == ref_dir) ||
                     ((ALLOW_REVERSE == 0) && (cand_dir == opposite(ref_dir))) ||
                     (full && !pop));
        push      = cand_valid && !reject;
        drop_next = multi || reject;
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= cand_dir;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            direction   <= DIR_IDLE;
            queue_count <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            drop        <= 1'b0;
        end else begin
            drop <= drop_next;
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop) begin
                direction <= mem[rd_ptr];
                rd_ptr    <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   queue_count <= queue_count + CW'(1);
                2'b01:   queue_count <= queue_count - CW'(1);
                default: queue_count <= queue_count;
            endcase
        end
    end

    assign queue_full = full;

endmodule
